// File: rtl/lmul_stream_master_if.sv
// Valid/ready channel pair between the stream master and one bf16 L-Mul instance.
// The master drives operands out on m_* and takes products back on r_*.
interface lmul_stream_master_if;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic        r_valid;
  logic        r_ready;
  logic [15:0] r_p;

  modport master (
    output m_valid, m_a, m_b, r_ready,
    input  m_ready, r_valid, r_p
  );

  modport slave (
    input  m_valid, m_a, m_b, r_ready,
    output m_ready, r_valid, r_p
  );
endinterface

// File: rtl/lmul_stream_master.sv
// Streams preloaded bf16 operand pairs into an L-Mul and collects the in-order products.
// Optional LMUL_MASTER_PERF_EN adds perf_cyc/perf_stall run counters.
module lmul_stream_master #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int MAX_OUT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_we,
  input  logic [AW-1:0]         ld_addr,
  input  logic [15:0]           ld_a,
  input  logic [15:0]           ld_b,
  input  logic                  start,
  input  logic [AW:0]           len,
  output logic                  busy,
  output logic                  done,
  input  logic [AW-1:0]         rd_addr,
  output logic [15:0]           rd_data,
`ifdef LMUL_MASTER_PERF_EN
  output logic [31:0]           perf_cyc,
  output logic [31:0]           perf_stall,
`endif
  lmul_stream_master_if.master  bus
);

  localparam logic [AW:0] DEPTH_L   = (AW+1)'(DEPTH);
  localparam logic [AW:0] MAX_OUT_L = (AW+1)'(MAX_OUT);
  localparam logic [AW:0] ONE_L     = (AW+1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [AW:0] len_q, len_d;
  logic [AW:0] iss_cnt_q, iss_cnt_d;
  logic [AW:0] rcv_cnt_q, rcv_cnt_d;
  logic        m_valid_q, m_valid_d;
  logic [15:0] m_a_q, m_a_d;
  logic [15:0] m_b_q, m_b_d;
  logic [15:0] rd_data_q;

  logic [15:0] op_a_mem [DEPTH];
  logic [15:0] op_b_mem [DEPTH];
  logic [15:0] res_mem  [DEPTH];

  logic        op_we;
  logic        res_we;
  logic [AW:0] len_eff;
  logic [AW:0] outstanding;
  logic        can_load;

  assign op_we       = (state_q == ST_IDLE) && ld_we;
  assign res_we      = (state_q == ST_RUN) && bus.r_valid;
  assign len_eff     = (len > DEPTH_L) ? DEPTH_L : len;
  assign outstanding = iss_cnt_q - rcv_cnt_q;
  assign can_load    = (!m_valid_q || bus.m_ready) && (iss_cnt_q < len_q) &&
                       (outstanding < MAX_OUT_L);

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    iss_cnt_d = iss_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    m_valid_d = m_valid_q;
    m_a_d     = m_a_q;
    m_b_d     = m_b_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d     = len_eff;
          iss_cnt_d = '0;
          rcv_cnt_d = '0;
          if (len_eff == '0) begin
            state_d = ST_DONE;
          end else begin
            // Pair 0 is issued on the start edge; forward a same-cycle write to entry 0.
            state_d   = ST_RUN;
            m_valid_d = 1'b1;
            iss_cnt_d = ONE_L;
            m_a_d     = (op_we && ld_addr == '0) ? ld_a : op_a_mem[0];
            m_b_d     = (op_we && ld_addr == '0) ? ld_b : op_b_mem[0];
          end
        end
      end
      ST_RUN: begin
        if (can_load) begin
          m_valid_d = 1'b1;
          m_a_d     = op_a_mem[iss_cnt_q[AW-1:0]];
          m_b_d     = op_b_mem[iss_cnt_q[AW-1:0]];
          iss_cnt_d = iss_cnt_q + ONE_L;
        end else if (m_valid_q && bus.m_ready) begin
          m_valid_d = 1'b0;
        end
        if (res_we) begin
          rcv_cnt_d = rcv_cnt_q + ONE_L;
        end
        if (rcv_cnt_d == len_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
      end
      default: begin
        state_d   = ST_IDLE;
        m_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      len_q     <= '0;
      iss_cnt_q <= '0;
      rcv_cnt_q <= '0;
      m_valid_q <= 1'b0;
      m_a_q     <= '0;
      m_b_q     <= '0;
      rd_data_q <= '0;
    end else begin
      state_q   <= state_d;
      len_q     <= len_d;
      iss_cnt_q <= iss_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      m_valid_q <= m_valid_d;
      m_a_q     <= m_a_d;
      m_b_q     <= m_b_d;
      rd_data_q <= res_mem[rd_addr];
    end
  end

  // Buffers carry no reset so they map onto plain RAM.
  always_ff @(posedge clk) begin
    if (op_we) begin
      op_a_mem[ld_addr] <= ld_a;
      op_b_mem[ld_addr] <= ld_b;
    end
    if (res_we) begin
      res_mem[rcv_cnt_q[AW-1:0]] <= bus.r_p;
    end
  end

`ifdef LMUL_MASTER_PERF_EN
  logic [31:0] perf_cyc_q, perf_cyc_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cyc_d   = perf_cyc_q;
    perf_stall_d = perf_stall_q;
    if (state_q == ST_IDLE && start) begin
      perf_cyc_d   = '0;
      perf_stall_d = '0;
    end else if (state_q != ST_IDLE) begin
      perf_cyc_d = perf_cyc_q + 32'd1;
      if (m_valid_q && !bus.m_ready) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cyc_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_cyc_q   <= perf_cyc_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_cyc   = perf_cyc_q;
  assign perf_stall = perf_stall_q;
`endif

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign rd_data     = rd_data_q;
  assign bus.m_valid = m_valid_q;
  assign bus.m_a     = m_a_q;
  assign bus.m_b     = m_b_q;
  assign bus.r_ready = (state_q == ST_RUN);

endmodule

// File: tb/tb_lmul_stream_master.sv
// Directed bench for lmul_stream_master with a latency/ready-configurable multiplier stub (p = a^b).
module tb_lmul_stream_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_we;
  logic [3:0]  ld_addr;
  logic [15:0] ld_a, ld_b;
  logic        start;
  logic [4:0]  len;
  logic        busy, done;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
`ifdef LMUL_MASTER_PERF_EN
  logic [31:0] perf_cyc, perf_stall;
`endif

  lmul_stream_master_if bus ();

  lmul_stream_master #(.DEPTH(16), .AW(4), .MAX_OUT(4)) dut (
    .clk(clk), .rst(rst), .ld_we(ld_we), .ld_addr(ld_addr), .ld_a(ld_a), .ld_b(ld_b),
    .start(start), .len(len), .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
`ifdef LMUL_MASTER_PERF_EN
    .perf_cyc(perf_cyc), .perf_stall(perf_stall),
`endif
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
  } vec_t;

  typedef struct {
    logic [15:0] p;
    int          due;
  } fl_t;

  vec_t        vec [16];
  logic [15:0] exp_a [16];
  logic [15:0] exp_b [16];
  logic [15:0] exp_p [16];

  int n_checks = 0;
  int n_fail   = 0;

  int lat      = 2;
  int rdy_mode = 0;
  int cyc      = 0;
  int hs_cnt, done_cnt, busy_cyc, stall_cyc, max_seen;
  bit saw_valid;
  bit prev_stall = 1'b0;
  logic [15:0] prev_a, prev_b;
  fl_t pipe [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Multiplier stub and bus monitor; runs mid-cycle so everything it reads is settled.
  always @(negedge clk) begin
    int out_now;
    cyc++;
    if (rst) begin
      pipe.delete();
      bus.m_ready = 1'b0;
      bus.r_valid = 1'b0;
      bus.r_p     = '0;
      prev_stall  = 1'b0;
    end else begin
      bus.m_ready = (rdy_mode == 0) ? 1'b1 : ~cyc[0];
      bus.r_valid = (pipe.size() > 0) && (pipe[0].due <= cyc);
      bus.r_p     = (pipe.size() > 0) ? pipe[0].p : 16'h0;
      out_now = pipe.size() + (bus.m_valid ? 1 : 0);
      if (out_now > max_seen) max_seen = out_now;
      if (bus.m_valid) saw_valid = 1'b1;
      if (prev_stall) begin
        check("stall_hold", 64'({bus.m_valid, bus.m_a, bus.m_b}), 64'({1'b1, prev_a, prev_b}));
      end
      if (bus.m_valid && bus.m_ready) begin
        if (hs_cnt < 16) begin
          check($sformatf("issue_pair%0d", hs_cnt), 64'({bus.m_a, bus.m_b}),
                64'({exp_a[hs_cnt], exp_b[hs_cnt]}));
        end
        pipe.push_back('{p: bus.m_a ^ bus.m_b, due: cyc + lat});
        hs_cnt++;
      end
      if (bus.r_valid && bus.r_ready) void'(pipe.pop_front());
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_a     = bus.m_a;
      prev_b     = bus.m_b;
      if (prev_stall) stall_cyc++;
      if (busy) busy_cyc++;
      if (done) done_cnt++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats;
    hs_cnt = 0; done_cnt = 0; busy_cyc = 0; stall_cyc = 0; max_seen = 0; saw_valid = 1'b0;
  endtask

  task automatic start_run(input logic [4:0] n);
    clear_stats();
    len   = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check({name, "_done_seen"}, 64'(seen), 64'(1));
    tick();
    check({name, "_idle_after"}, 64'({busy, done}), 64'(0));
  endtask

  task automatic readback(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      rd_addr = 4'(i);
      tick();
      check($sformatf("%s_rd%0d", name, i), 64'(rd_data), 64'(exp_p[i]));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec[0]  = '{16'h3F80, 16'h4000, 16'h7F80};
    vec[1]  = '{16'h4040, 16'h3F80, 16'h7FC0};
    vec[2]  = '{16'hC000, 16'h4000, 16'h8000};
    vec[3]  = '{16'h1234, 16'h0000, 16'h1234};
    vec[4]  = '{16'hFFFF, 16'h0F0F, 16'hF0F0};
    vec[5]  = '{16'hAAAA, 16'h5555, 16'hFFFF};
    vec[6]  = '{16'h0001, 16'h0002, 16'h0003};
    vec[7]  = '{16'h4100, 16'h4100, 16'h0000};
    vec[8]  = '{16'h8000, 16'h0001, 16'h8001};
    vec[9]  = '{16'h3C00, 16'h0300, 16'h3F00};
    vec[10] = '{16'h00FF, 16'hFF00, 16'hFFFF};
    vec[11] = '{16'h1111, 16'h2222, 16'h3333};
    vec[12] = '{16'h4480, 16'h0080, 16'h4400};
    vec[13] = '{16'hBF80, 16'h3F80, 16'h8000};
    vec[14] = '{16'h7F80, 16'h0080, 16'h7F00};
    vec[15] = '{16'h0F00, 16'h00F0, 16'h0FF0};
    for (int i = 0; i < 16; i++) begin
      exp_a[i] = vec[i].a; exp_b[i] = vec[i].b; exp_p[i] = vec[i].p;
    end
    clear_stats();

    rst = 1'b1; ld_we = 1'b0; ld_addr = '0; ld_a = '0; ld_b = '0;
    start = 1'b0; len = '0; rd_addr = '0;
    repeat (3) tick();
    check("reset_outputs", 64'({busy, done, bus.m_valid, bus.r_ready}), 64'(0));
    check("reset_m_ab", 64'({bus.m_a, bus.m_b}), 64'(0));
    check("reset_rd_data", 64'(rd_data), 64'(0));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 16; i++) begin
      ld_we = 1'b1; ld_addr = 4'(i); ld_a = vec[i].a; ld_b = vec[i].b;
      tick();
    end
    ld_we = 1'b0;

    // Single pair, latency 2
    lat = 2; rdy_mode = 0;
    start_run(5'd1);
    check("t1_first_valid", 64'({busy, bus.m_valid, bus.m_a}), 64'({1'b1, 1'b1, 16'h3F80}));
    wait_done("t1");
    check("t1_handshakes", 64'(hs_cnt), 64'(1));
    check("t1_done_pulses", 64'(done_cnt), 64'(1));
    readback("t1", 1);

    // Full buffer, deep latency: outstanding capped at MAX_OUT
    lat = 8;
    start_run(5'd16);
    wait_done("t2");
    check("t2_handshakes", 64'(hs_cnt), 64'(16));
    check("t2_done_pulses", 64'(done_cnt), 64'(1));
    check("t2_max_outstanding", 64'(max_seen), 64'(4));
    readback("t2", 16);

    // Alternating ready
    lat = 3; rdy_mode = 1;
    start_run(5'd5);
    wait_done("t3");
    check("t3_handshakes", 64'(hs_cnt), 64'(5));
    check("t3_stalls_seen", 64'(stall_cyc > 0), 64'(1));
`ifdef LMUL_MASTER_PERF_EN
    check("t3_perf_stall", 64'(perf_stall), 64'(stall_cyc));
    check("t3_perf_cyc", 64'(perf_cyc), 64'(busy_cyc));
`endif
    readback("t3", 5);

    // len == 0 and saturating len
    rdy_mode = 0; lat = 2;
    start_run(5'd0);
    check("t4_len0_done", 64'({done, bus.m_valid}), 64'({1'b1, 1'b0}));
    wait_done("t4a");
    check("t4_len0_no_valid", 64'({saw_valid, 8'(hs_cnt)}), 64'(0));
    check("t4_len0_done_pulses", 64'(done_cnt), 64'(1));
    start_run(5'd20);
    wait_done("t4b");
    check("t4_len20_handshakes", 64'(hs_cnt), 64'(16));
    readback("t4b", 16);

    // Reset during a run, then a clean run
    lat = 8;
    start_run(5'd16);
    for (int i = 0; i < 100 && hs_cnt < 2; i++) tick();
    check("t5_reached_iss3", 64'(hs_cnt), 64'(2));
    rst = 1'b1;
    tick();
    check("t5_after_rst", 64'({busy, done, bus.m_valid, bus.r_ready}), 64'(0));
    rst = 1'b0;
    tick();
    lat = 1;
    start_run(5'd4);
    wait_done("t5");
    check("t5_handshakes", 64'(hs_cnt), 64'(4));
    check("t5_done_pulses", 64'(done_cnt), 64'(1));
    readback("t5", 4);

    // start and ld_we while busy are ignored
    lat = 4;
    start_run(5'd4);
    tick();
    ld_we = 1'b1; ld_addr = 4'd0; ld_a = 16'hDEAD; ld_b = 16'hBEEF; start = 1'b1; len = 5'd1;
    tick();
    ld_we = 1'b0; start = 1'b0;
    wait_done("t6a");
    check("t6_handshakes", 64'(hs_cnt), 64'(4));
    check("t6_done_pulses", 64'(done_cnt), 64'(1));
    lat = 2;
    start_run(5'd1);
    wait_done("t6b");
    check("t6b_handshakes", 64'(hs_cnt), 64'(1));
    readback("t6b", 1);

    // Write and start in the same cycle: the run uses the new pair
    exp_a[0] = 16'h1111; exp_b[0] = 16'h0001; exp_p[0] = 16'h1110;
    clear_stats();
    ld_we = 1'b1; ld_addr = 4'd0; ld_a = 16'h1111; ld_b = 16'h0001; start = 1'b1; len = 5'd1;
    tick();
    ld_we = 1'b0; start = 1'b0;
    wait_done("t7");
    check("t7_handshakes", 64'(hs_cnt), 64'(1));
    readback("t7", 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
